// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for a shared register bank, with locked bursts
// that let one requester keep the bank for up to MAX_BURST writes.
module reg_write_arbiter #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned N_REGS    = 8,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned ADDR_W   = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [N_REQ-1:0]          Req,
    input  logic [N_REQ-1:0]          Lock,
    input  logic [N_REQ*ADDR_W-1:0]   Addr,
    input  logic [N_REQ*WIDTH-1:0]    Wdata,
    output logic [N_REQ-1:0]          Ack,
    output logic [N_REGS-1:0]         Reg_Load_En,
    output logic [WIDTH-1:0]          Reg_Data_in,
    output logic                      Err
);

    localparam int unsigned PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned BURST_W = 4;
    localparam logic [PTR_W:0]  NREQ_L  = (PTR_W+1)'(N_REQ);
    localparam logic [ADDR_W:0] NREGS_L = (ADDR_W+1)'(N_REGS);
    localparam logic [BURST_W-1:0] MAXB_L = BURST_W'(MAX_BURST);

    typedef enum logic [0:0] {StArb, StLocked} state_t;

    state_t              state_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    owner_q;
    logic [BURST_W-1:0]  burst_q;
    logic [N_REQ-1:0]    ack_q;
    logic [N_REGS-1:0]   load_q;
    logic [WIDTH-1:0]    data_q;
    logic                err_q;

    logic [ADDR_W-1:0]   addr_arr  [N_REQ];
    logic [WIDTH-1:0]    wdata_arr [N_REQ];

    logic [N_REQ-1:0]    elig;
    logic                exit_lock;
    logic                grant_valid;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W:0]      cand;
    logic [ADDR_W-1:0]   g_addr;
    logic                addr_ok;
    logic [N_REGS-1:0]   load_d;
    logic [PTR_W-1:0]    ptr_next;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            addr_arr[i]  = Addr[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = Wdata[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        // A requester acked in the previous cycle is never eligible.
        elig      = Req & ~ack_q;
        exit_lock = 1'b0;
        if (state_q == StLocked) begin
            if (!ack_q[owner_q] &&
                (!Req[owner_q] || !Lock[owner_q] || burst_q == MAXB_L)) begin
                exit_lock       = 1'b1;
                elig[owner_q]   = 1'b0;
            end else begin
                elig          = '0;
                elig[owner_q] = Req[owner_q] & ~ack_q[owner_q];
            end
        end

        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (cand >= NREQ_L) begin
                cand = cand - NREQ_L;
            end
            if (!grant_valid && elig[cand[PTR_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end

        g_addr  = addr_arr[grant_idx];
        addr_ok = ({1'b0, g_addr} < NREGS_L);
        load_d  = '0;
        for (int r = 0; r < N_REGS; r++) begin
            load_d[r] = addr_ok && ({1'b0, g_addr} == (ADDR_W+1)'(r));
        end

        ptr_next = (grant_idx == PTR_W'(N_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= StArb;
            ptr_q   <= '0;
            owner_q <= '0;
            burst_q <= '0;
            ack_q   <= '0;
            load_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            ack_q  <= '0;
            load_q <= '0;
            err_q  <= 1'b0;
            if (exit_lock) begin
                state_q <= StArb;
            end
            if (grant_valid) begin
                ack_q[grant_idx] <= 1'b1;
                data_q           <= wdata_arr[grant_idx];
                load_q           <= load_d;
                err_q            <= !addr_ok;
                ptr_q            <= ptr_next;
                if (state_q == StLocked && !exit_lock) begin
                    burst_q <= burst_q + BURST_W'(1);
                end else if (Lock[grant_idx] && MAX_BURST > 1) begin
                    state_q <= StLocked;
                    owner_q <= grant_idx;
                    burst_q <= BURST_W'(1);
                end
            end
        end
    end

    assign Ack         = ack_q;
    assign Reg_Load_En = load_q;
    assign Reg_Data_in = data_q;
    assign Err         = err_q;

endmodule
